// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the Mem stage: opcodes, load/store kinds, exception codes and
// the data-memory / device address map.
package mem_stage_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [31:0] DM_TOP   = 32'h0000_2FFF;
    localparam logic [31:0] DEV_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEV_TOP  = 32'h0000_7F1F;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [2:0] {
        LT_NONE,
        LT_LW,
        LT_LH,
        LT_LHU,
        LT_LB,
        LT_LBU
    } load_type_e;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_SW,
        ST_SH,
        ST_SB
    } store_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu_ans;
        logic [31:0] grf_rd2;
        logic [31:0] grf_wd;
        logic [4:0]  exc_code;
        logic        if_bd;
        logic        if_wr_grf;
        logic [4:0]  grf_wa;
        logic [4:0]  t_new;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] grf_wd;
        logic [4:0]  grf_wa;
        logic        if_wr_grf;
        load_type_e  load_type;
        logic [1:0]  offset;
    } mem_wb_t;

    function automatic load_type_e decode_load(input logic [5:0] op);
        case (op)
            OP_LW:   return LT_LW;
            OP_LH:   return LT_LH;
            OP_LHU:  return LT_LHU;
            OP_LB:   return LT_LB;
            OP_LBU:  return LT_LBU;
            default: return LT_NONE;
        endcase
    endfunction

    function automatic store_type_e decode_store(input logic [5:0] op);
        case (op)
            OP_SW:   return ST_SW;
            OP_SH:   return ST_SH;
            OP_SB:   return ST_SB;
            default: return ST_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory / bridge bus driven by the Mem stage; read data returns one cycle after the address.
interface mem_stage_if;
    logic [31:0] dmAddr;
    logic [31:0] dmWd;
    logic [3:0]  dmByteEn;
    logic [31:0] dmRd;

    modport master (
        output dmAddr,
        output dmWd,
        output dmByteEn,
        input  dmRd
    );

    modport slave (
        input  dmAddr,
        input  dmWd,
        input  dmByteEn,
        output dmRd
    );
endinterface

// File: rtl/mem_stage_load_extend.sv
// Picks the addressed byte/half/word out of the DM read word and sign- or zero-extends it.
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rd_i,
    input  logic [1:0]  offset_i,
    input  load_type_e  load_type_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? rd_i[31:16] : rd_i[15:0];
        case (load_type_i)
            LT_LW:   ext_o = rd_i;
            LT_LH:   ext_o = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  ext_o = {16'h0000, half_sel};
            LT_LB:   ext_o = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  ext_o = {24'h000000, byte_sel};
            default: ext_o = rd_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Ex->Mem register, store-lane / address-exception logic, and Mem->Wb register with load extraction.
// Mem never stalls; CP0 flush or reset turns both registers into a nop bubble.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_Cp0,

    input  logic [31:0] pc_ExMem,
    input  logic [31:0] instr_ExMem,
    input  logic [31:0] aluAns_ExMem,
    input  logic [31:0] grfRd2_ExMem,
    input  logic [31:0] grfWd_ExMem,
    input  logic [4:0]  excCode_ExMem,
    input  logic        ifBd_ExMem,
    input  logic        ifWrGrf_ExMem,
    input  logic [4:0]  grfWa_ExMem,
    input  logic [4:0]  tNew_ExMem,

    mem_stage_if.master dm,

    output logic [31:0] pc_Mem,
    output logic [4:0]  excCode_Mem,
    output logic        ifBd_Mem,

    output logic [31:0] fwdData_Mem,
    output logic        ifWrGrf_Mem,
    output logic [4:0]  grfWa_Mem,
    output logic [4:0]  tNew_Mem,

    output logic [31:0] grfWd_MemWb,
    output logic [4:0]  grfWa_MemWb,
    output logic        ifWrGrf_MemWb,
    output logic [31:0] pc_MemWb
);

    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;

    logic        kill;
    load_type_e  load_type;
    store_type_e store_type;
    logic        is_load, is_store, is_word, is_half;
    logic [31:0] addr, dev_off;
    logic        in_dm, in_dev, is_count, misalign, addr_err;
    logic [4:0]  exc_code;
    logic [3:0]  lane_en;
    logic [31:0] lane_wd;
    logic        wb_we;
    logic [31:0] load_data;
    logic        unused_instr;

    assign kill = reset | flush_Cp0;

    always_comb begin
        ex_mem_d = '0;
        if (!kill) begin
            ex_mem_d.pc        = pc_ExMem;
            ex_mem_d.instr     = instr_ExMem;
            ex_mem_d.alu_ans   = aluAns_ExMem;
            ex_mem_d.grf_rd2   = grfRd2_ExMem;
            ex_mem_d.grf_wd    = grfWd_ExMem;
            ex_mem_d.exc_code  = excCode_ExMem;
            ex_mem_d.if_bd     = ifBd_ExMem;
            ex_mem_d.if_wr_grf = ifWrGrf_ExMem;
            ex_mem_d.grf_wa    = grfWa_ExMem;
            ex_mem_d.t_new     = tNew_ExMem;
        end
    end

    always_ff @(posedge clk) begin
        ex_mem_q <= ex_mem_d;
    end

    // Only the opcode field matters from here on.
    assign unused_instr = ^ex_mem_q.instr[25:0];

    assign load_type  = decode_load(ex_mem_q.instr[31:26]);
    assign store_type = decode_store(ex_mem_q.instr[31:26]);
    assign addr       = ex_mem_q.alu_ans;

    always_comb begin
        is_load  = (load_type != LT_NONE);
        is_store = (store_type != ST_NONE);
        is_word  = (load_type == LT_LW) || (store_type == ST_SW);
        is_half  = (load_type == LT_LH) || (load_type == LT_LHU) || (store_type == ST_SH);
        in_dm    = (addr <= DM_TOP);
        in_dev   = (addr >= DEV_BASE) && (addr <= DEV_TOP);
        dev_off  = addr - DEV_BASE;
        // Timer COUNT registers are read-only.
        is_count = in_dev && (((dev_off >= 32'h08) && (dev_off <= 32'h0B)) ||
                              ((dev_off >= 32'h18) && (dev_off <= 32'h1B)));
        misalign = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
        addr_err = misalign || !(in_dm || in_dev) || (in_dev && !is_word) ||
                   (is_store && is_count);

        exc_code = ex_mem_q.exc_code;
        if ((ex_mem_q.exc_code == EXC_NONE) && (is_load || is_store) && addr_err) begin
            exc_code = is_load ? EXC_ADEL : EXC_ADES;
        end
    end

    always_comb begin
        lane_en = 4'b0000;
        lane_wd = ex_mem_q.grf_rd2;
        case (store_type)
            ST_SW: lane_en = 4'b1111;
            ST_SH: begin
                lane_en = addr[1] ? 4'b1100 : 4'b0011;
                lane_wd = {2{ex_mem_q.grf_rd2[15:0]}};
            end
            ST_SB: begin
                lane_en = 4'b0001 << addr[1:0];
                lane_wd = {4{ex_mem_q.grf_rd2[7:0]}};
            end
            default: lane_en = 4'b0000;
        endcase
    end

    assign dm.dmAddr   = addr;
    assign dm.dmWd     = lane_wd;
    assign dm.dmByteEn = (kill || (exc_code != EXC_NONE)) ? 4'b0000 : lane_en;

    assign pc_Mem      = ex_mem_q.pc;
    assign excCode_Mem = exc_code;
    assign ifBd_Mem    = ex_mem_q.if_bd;
    assign fwdData_Mem = ex_mem_q.grf_wd;
    assign ifWrGrf_Mem = ex_mem_q.if_wr_grf && (ex_mem_q.grf_wa != 5'd0);
    assign grfWa_Mem   = ex_mem_q.grf_wa;
    assign tNew_Mem    = ex_mem_q.t_new;

    // A faulting instruction must not reach the register file.
    assign wb_we = ex_mem_q.if_wr_grf && (ex_mem_q.grf_wa != 5'd0) && (exc_code == EXC_NONE);

    always_comb begin
        mem_wb_d = '0;
        if (!kill) begin
            mem_wb_d.pc        = ex_mem_q.pc;
            mem_wb_d.grf_wd    = ex_mem_q.grf_wd;
            mem_wb_d.grf_wa    = wb_we ? ex_mem_q.grf_wa : 5'd0;
            mem_wb_d.if_wr_grf = wb_we;
            mem_wb_d.load_type = (exc_code == EXC_NONE) ? load_type : LT_NONE;
            mem_wb_d.offset    = addr[1:0];
        end
    end

    always_ff @(posedge clk) begin
        mem_wb_q <= mem_wb_d;
    end

    mem_stage_load_extend u_load_extend (
        .rd_i        (dm.dmRd),
        .offset_i    (mem_wb_q.offset),
        .load_type_i (mem_wb_q.load_type),
        .ext_o       (load_data)
    );

    assign grfWd_MemWb   = (mem_wb_q.load_type != LT_NONE) ? load_data : mem_wb_q.grf_wd;
    assign grfWa_MemWb   = mem_wb_q.grf_wa;
    assign ifWrGrf_MemWb = mem_wb_q.if_wr_grf;
    assign pc_MemWb      = mem_wb_q.pc;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a stimulus process pushes hand-computed expectations, a monitor
// pops them when the instruction reaches Mem and again when it reaches Wb.
module tb_mem_stage;

    typedef struct {
        string       name;
        int          cyc;
        logic [3:0]  en;
        logic [31:0] wd;
        logic [4:0]  exc;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] fwd;
        logic [4:0]  tnew;
        logic        we_mem;
        logic        bd;
        logic        wb_we;
        logic [4:0]  wb_wa;
        logic [31:0] wb_wd;
        logic [31:0] wb_pc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush_Cp0;
    logic [31:0] pc_ExMem, instr_ExMem, aluAns_ExMem, grfRd2_ExMem, grfWd_ExMem;
    logic [4:0]  excCode_ExMem, grfWa_ExMem, tNew_ExMem;
    logic        ifBd_ExMem, ifWrGrf_ExMem;
    logic [31:0] pc_Mem, fwdData_Mem, grfWd_MemWb, pc_MemWb;
    logic [4:0]  excCode_Mem, grfWa_Mem, tNew_Mem, grfWa_MemWb;
    logic        ifBd_Mem, ifWrGrf_Mem, ifWrGrf_MemWb;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    exp_t mem_q[$];
    exp_t wb_q[$];
    exp_t mon_m, mon_w;
    logic [31:0] dm_mem [0:255];

    mem_stage_if bus ();

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .flush_Cp0     (flush_Cp0),
        .pc_ExMem      (pc_ExMem),
        .instr_ExMem   (instr_ExMem),
        .aluAns_ExMem  (aluAns_ExMem),
        .grfRd2_ExMem  (grfRd2_ExMem),
        .grfWd_ExMem   (grfWd_ExMem),
        .excCode_ExMem (excCode_ExMem),
        .ifBd_ExMem    (ifBd_ExMem),
        .ifWrGrf_ExMem (ifWrGrf_ExMem),
        .grfWa_ExMem   (grfWa_ExMem),
        .tNew_ExMem    (tNew_ExMem),
        .dm            (bus),
        .pc_Mem        (pc_Mem),
        .excCode_Mem   (excCode_Mem),
        .ifBd_Mem      (ifBd_Mem),
        .fwdData_Mem   (fwdData_Mem),
        .ifWrGrf_Mem   (ifWrGrf_Mem),
        .grfWa_Mem     (grfWa_Mem),
        .tNew_Mem      (tNew_Mem),
        .grfWd_MemWb   (grfWd_MemWb),
        .grfWa_MemWb   (grfWa_MemWb),
        .ifWrGrf_MemWb (ifWrGrf_MemWb),
        .pc_MemWb      (pc_MemWb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read data memory: writes land at the edge, reads see earlier writes.
    always @(posedge clk) begin
        logic [31:0] w;
        if (reset) begin
            for (int i = 0; i < 256; i++) dm_mem[i] <= 32'h0;
            dm_mem[8'h40] <= 32'h8001_7FFF;
            dm_mem[8'h80] <= 32'hDEAD_BEEF;
            bus.dmRd <= 32'h0;
        end else begin
            w = dm_mem[bus.dmAddr[9:2]];
            for (int i = 0; i < 4; i++) begin
                if (bus.dmByteEn[i]) w[8*i +: 8] = bus.dmWd[8*i +: 8];
            end
            dm_mem[bus.dmAddr[9:2]] <= w;
            bus.dmRd <= dm_mem[bus.dmAddr[9:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] en, input logic [31:0] wd, input logic [4:0] exc,
                                input logic [31:0] pc, input logic [31:0] addr,
                                input logic [31:0] fwd, input logic [4:0] tnew, input logic we_mem,
                                input logic bd, input logic wb_we, input logic [4:0] wb_wa,
                                input logic [31:0] wb_wd, input logic [31:0] wb_pc);
        exp_t e;
        e.name = "";
        e.cyc = 0;
        e.en = en; e.wd = wd; e.exc = exc; e.pc = pc; e.addr = addr; e.fwd = fwd;
        e.tnew = tnew; e.we_mem = we_mem; e.bd = bd;
        e.wb_we = wb_we; e.wb_wa = wb_wa; e.wb_wd = wb_wd; e.wb_pc = wb_pc;
        return e;
    endfunction

    // flush/rst act on the instruction already in Mem during this cycle.
    task automatic issue(input string nm, input logic [5:0] op, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] wd,
                         input logic [4:0] exc_in, input logic we, input logic [4:0] wa,
                         input logic [4:0] tnew, input logic bd, input logic flush,
                         input logic rst, input exp_t e);
        exp_t x;
        @(posedge clk);
        #1;
        reset         = rst;
        flush_Cp0     = flush;
        pc_ExMem      = pc;
        instr_ExMem   = {op, 26'h0A5_5A5A};
        aluAns_ExMem  = alu;
        grfRd2_ExMem  = rt;
        grfWd_ExMem   = wd;
        excCode_ExMem = exc_in;
        ifWrGrf_ExMem = we;
        grfWa_ExMem   = wa;
        tNew_ExMem    = tnew;
        ifBd_ExMem    = bd;
        x = e;
        x.name = nm;
        x.cyc = cyc + 1;
        mem_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (wb_q.size() > 0 && wb_q[0].cyc <= cyc) begin
            mon_w = wb_q.pop_front();
            chk({mon_w.name, "/ifWrGrf_MemWb"}, {31'h0, ifWrGrf_MemWb}, {31'h0, mon_w.wb_we});
            chk({mon_w.name, "/grfWa_MemWb"}, {27'h0, grfWa_MemWb}, {27'h0, mon_w.wb_wa});
            chk({mon_w.name, "/grfWd_MemWb"}, grfWd_MemWb, mon_w.wb_wd);
            chk({mon_w.name, "/pc_MemWb"}, pc_MemWb, mon_w.wb_pc);
        end
        if (mem_q.size() > 0 && mem_q[0].cyc <= cyc) begin
            mon_m = mem_q.pop_front();
            chk({mon_m.name, "/dmByteEn"}, {28'h0, bus.dmByteEn}, {28'h0, mon_m.en});
            chk({mon_m.name, "/dmWd"}, bus.dmWd, mon_m.wd);
            chk({mon_m.name, "/dmAddr"}, bus.dmAddr, mon_m.addr);
            chk({mon_m.name, "/excCode_Mem"}, {27'h0, excCode_Mem}, {27'h0, mon_m.exc});
            chk({mon_m.name, "/pc_Mem"}, pc_Mem, mon_m.pc);
            chk({mon_m.name, "/ifBd_Mem"}, {31'h0, ifBd_Mem}, {31'h0, mon_m.bd});
            chk({mon_m.name, "/fwdData_Mem"}, fwdData_Mem, mon_m.fwd);
            chk({mon_m.name, "/tNew_Mem"}, {27'h0, tNew_Mem}, {27'h0, mon_m.tnew});
            chk({mon_m.name, "/ifWrGrf_Mem"}, {31'h0, ifWrGrf_Mem}, {31'h0, mon_m.we_mem});
            mon_m.cyc = cyc + 1;
            wb_q.push_back(mon_m);
        end
    end

    initial begin
        exp_t z;
        z = mk(4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        flush_Cp0 = 1'b0;
        pc_ExMem = 32'h3000; instr_ExMem = {6'h2B, 26'h0}; aluAns_ExMem = 32'h10;
        grfRd2_ExMem = 32'h1234_5678; grfWd_ExMem = 32'h55; excCode_ExMem = 5'd0;
        ifWrGrf_ExMem = 1'b1; grfWa_ExMem = 5'd3; tNew_ExMem = 5'd1; ifBd_ExMem = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/dmByteEn", {28'h0, bus.dmByteEn}, 32'h0);
        chk("reset/dmAddr", bus.dmAddr, 32'h0);
        chk("reset/dmWd", bus.dmWd, 32'h0);
        chk("reset/pc_Mem", pc_Mem, 32'h0);
        chk("reset/excCode_Mem", {27'h0, excCode_Mem}, 32'h0);
        chk("reset/ifWrGrf_MemWb", {31'h0, ifWrGrf_MemWb}, 32'h0);
        chk("reset/grfWd_MemWb", grfWd_MemWb, 32'h0);
        chk("reset/pc_MemWb", pc_MemWb, 32'h0);

        //    name        op     pc       alu       rt            wd       exc we wa tn bd fl rs
        issue("sw_10", 6'h2B, 32'h3000, 32'h10, 32'h1234_5678, 32'h0, 0, 0, 0, 0, 0, 0, 0,
              mk(4'hF, 32'h1234_5678, 0, 32'h3000, 32'h10, 0, 0, 0, 0, 0, 0, 0, 32'h3000));
        issue("sb_13", 6'h28, 32'h3004, 32'h13, 32'hAB, 32'h0, 0, 0, 0, 0, 0, 0, 0,
              mk(4'h8, 32'hABAB_ABAB, 0, 32'h3004, 32'h13, 0, 0, 0, 0, 0, 0, 0, 32'h3004));
        issue("lb_13", 6'h20, 32'h3008, 32'h13, 32'h0, 32'h0, 0, 1, 8, 1, 0, 0, 0,
              mk(4'h0, 0, 0, 32'h3008, 32'h13, 0, 1, 1, 0, 1, 8, 32'hFFFF_FFAB, 32'h3008));
        issue("lbu_13", 6'h24, 32'h300C, 32'h13, 32'h0, 32'h0, 0, 1, 9, 1, 0, 0, 0,
              mk(4'h0, 0, 0, 32'h300C, 32'h13, 0, 1, 1, 0, 1, 9, 32'h0000_00AB, 32'h300C));
        issue("lh_102", 6'h21, 32'h3010, 32'h102, 32'h0, 32'h0, 0, 1, 10, 1, 0, 0, 0,
              mk(4'h0, 0, 0, 32'h3010, 32'h102, 0, 1, 1, 0, 1, 10, 32'hFFFF_8001, 32'h3010));
        issue("lhu_100", 6'h25, 32'h3014, 32'h100, 32'h0, 32'h0, 0, 1, 11, 1, 0, 0, 0,
              mk(4'h0, 0, 0, 32'h3014, 32'h100, 0, 1, 1, 0, 1, 11, 32'h0000_7FFF, 32'h3014));
        issue("lw_6_adel", 6'h23, 32'h3018, 32'h6, 32'h0, 32'h0, 0, 1, 12, 1, 0, 0, 0,
              mk(4'h0, 0, 5'd4, 32'h3018, 32'h6, 0, 1, 1, 0, 0, 0, 0, 32'h3018));
        issue("lw_10", 6'h23, 32'h301C, 32'h10, 32'h0, 32'h0, 0, 1, 12, 1, 0, 0, 0,
              mk(4'h0, 0, 0, 32'h301C, 32'h10, 0, 1, 1, 0, 1, 12, 32'hAB34_5678, 32'h301C));
        issue("sh_dev", 6'h29, 32'h3020, 32'h7F04, 32'hBEEF, 32'h0, 0, 0, 0, 0, 0, 0, 0,
              mk(4'h0, 32'hBEEF_BEEF, 5'd5, 32'h3020, 32'h7F04, 0, 0, 0, 0, 0, 0, 0, 32'h3020));
        issue("sw_count", 6'h2B, 32'h3024, 32'h7F08, 32'h11, 32'h0, 0, 0, 0, 0, 0, 0, 0,
              mk(4'h0, 32'h11, 5'd5, 32'h3024, 32'h7F08, 0, 0, 0, 0, 0, 0, 0, 32'h3024));
        issue("sw_dev", 6'h2B, 32'h3028, 32'h7F04, 32'h22, 32'h0, 0, 0, 0, 0, 0, 0, 0,
              mk(4'hF, 32'h22, 0, 32'h3028, 32'h7F04, 0, 0, 0, 0, 0, 0, 0, 32'h3028));
        issue("sw_flushed", 6'h2B, 32'h302C, 32'h20, 32'h55, 32'h0, 0, 0, 0, 0, 0, 0, 0,
              mk(4'h0, 32'h55, 0, 32'h302C, 32'h20, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        issue("alu_in_flush", 6'h00, 32'h3030, 32'h1, 32'h2, 32'h99, 0, 1, 3, 0, 1, 1, 0, z);
        issue("sw_exc12", 6'h2B, 32'h3034, 32'h3, 32'h44, 32'h0, 5'd12, 0, 0, 0, 0, 0, 0,
              mk(4'h0, 32'h44, 5'd12, 32'h3034, 32'h3, 0, 0, 0, 0, 0, 0, 0, 32'h3034));
        issue("alu_wr5", 6'h00, 32'h3038, 32'h1234, 32'h0, 32'hCAFE_0001, 0, 1, 5, 0, 1, 0, 0,
              mk(4'h0, 0, 0, 32'h3038, 32'h1234, 32'hCAFE_0001, 0, 1, 1, 1, 5, 32'hCAFE_0001,
                 32'h3038));
        issue("alu_wr0", 6'h00, 32'h303C, 32'h0, 32'h0, 32'h77, 0, 1, 0, 0, 0, 0, 0,
              mk(4'h0, 0, 0, 32'h303C, 32'h0, 32'h77, 0, 0, 0, 0, 0, 32'h77, 32'h303C));
        issue("lw_reset", 6'h23, 32'h3040, 32'h200, 32'h0, 32'h0, 0, 1, 7, 1, 0, 0, 0,
              mk(4'h0, 0, 0, 32'h3040, 32'h200, 0, 1, 1, 0, 0, 0, 0, 32'h0));
        issue("sw_in_reset", 6'h2B, 32'h3044, 32'h10, 32'h66, 32'h0, 0, 1, 6, 0, 0, 0, 1, z);
        issue("lw_3000", 6'h23, 32'h3048, 32'h3000, 32'h0, 32'h0, 0, 1, 7, 1, 0, 0, 0,
              mk(4'h0, 0, 5'd4, 32'h3048, 32'h3000, 0, 1, 1, 0, 0, 0, 0, 32'h3048));
        issue("sh_0", 6'h29, 32'h304C, 32'h0, 32'h1234, 32'h0, 0, 0, 0, 0, 0, 0, 0,
              mk(4'h3, 32'h1234_1234, 0, 32'h304C, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h304C));
        issue("lhu_0", 6'h25, 32'h3050, 32'h0, 32'h0, 32'h0, 0, 1, 2, 1, 0, 0, 0,
              mk(4'h0, 0, 0, 32'h3050, 32'h0, 0, 1, 1, 0, 1, 2, 32'h0000_1234, 32'h3050));
        issue("sb_101", 6'h28, 32'h3054, 32'h101, 32'hC3, 32'h0, 0, 0, 0, 0, 0, 0, 0,
              mk(4'h2, 32'hC3C3_C3C3, 0, 32'h3054, 32'h101, 0, 0, 0, 0, 0, 0, 0, 32'h3054));
        issue("lb_101", 6'h20, 32'h3058, 32'h101, 32'h0, 32'h0, 0, 1, 4, 1, 0, 0, 0,
              mk(4'h0, 0, 0, 32'h3058, 32'h101, 0, 1, 1, 0, 1, 4, 32'hFFFF_FFC3, 32'h3058));
        issue("nop_a", 6'h00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, z);
        issue("nop_b", 6'h00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, z);

        for (int i = 0; i < 20 && (mem_q.size() > 0 || wb_q.size() > 0); i++) @(posedge clk);
        @(negedge clk);
        if (mem_q.size() > 0 || wb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expectations, required 0",
                     mem_q.size() + wb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
